mcpu_ctrl: RTL and testbench

Multicycle control FSM that sequences the shared MIPS datapath (single ALU, single unified memory, register file) for the multicycle CPU variant. Decodes the 6-bit opcode latched in IR. Drives Moore-style control strobes per state and reports a retired-instruction count. ALU function decode stays in the existing ALU-control block via ALUop.

---
 rtl/mcpu_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_mcpu_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mcpu_ctrl.sv
// Multicycle MIPS control FSM: sequences the shared datapath and counts retired instructions.
// Optional MEM_WAIT_EN macro: FETCH/MEMRD/MEMWR stall until mem_ready is high.
module mcpu_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [5:0]       Op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWr,
  output logic             PCWrCond,
  output logic             PCEn,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWr,
  output logic             IRWr,
  output logic             M2R,
  output logic             RegDst,
  output logic             regWr,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUop,
  output logic [1:0]       PCSrc,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             mem_ok;
  logic             retire;

`ifdef MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  always_comb begin
    state_d = S_FETCH;
    illegal = 1'b0;
    case (state_q)
      S_FETCH:  state_d = mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_R:         state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ok ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ok ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // An instruction retires on the edge that leaves its final state.
  always_comb begin
    case (state_q)
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: retire = 1'b1;
      S_MEMWR:                                    retire = mem_ok;
      default:                                    retire = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Moore decode; write/read strobes are held low while reset is asserted.
  always_comb begin
    PCWr     = 1'b0;
    PCWrCond = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWr    = 1'b0;
    IRWr     = 1'b0;
    M2R      = 1'b0;
    RegDst   = 1'b0;
    regWr    = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUop    = 2'b00;
    PCSrc    = 2'b00;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWr    = mem_ok;
        PCWr    = mem_ok;
        ALUSrcB = 2'b01;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        M2R   = 1'b1;
        regWr = 1'b1;
      end
      S_MEMWR: begin
        MemWr = 1'b1;
        IorD  = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = 2'b10;
      end
      S_RWB: begin
        RegDst = 1'b1;
        regWr  = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUop    = 2'b01;
        PCWrCond = 1'b1;
        PCSrc    = 2'b01;
      end
      S_JUMP: begin
        PCWr  = 1'b1;
        PCSrc = 2'b10;
      end
      S_ADDIWB: regWr = 1'b1;
      default: ;
    endcase
    if (reset) begin
      PCWr     = 1'b0;
      PCWrCond = 1'b0;
      IRWr     = 1'b0;
      MemRead  = 1'b0;
      MemWr    = 1'b0;
    end
  end

  assign PCEn      = PCWr | (PCWrCond & zero);
  assign state     = state_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Bench for mcpu_ctrl: directed and random instruction streams against a per-opcode path model.
module tb_mcpu_ctrl;

  logic       CLK = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic       zero;
  logic       mem_ready;

  logic PCWr, PCWrCond, PCEn, IorD, MemRead, MemWr, IRWr, M2R, RegDst, regWr, ALUSrcA, illegal;
  logic [1:0]  ALUSrcB, ALUop, PCSrc;
  logic [3:0]  state;
  logic [15:0] instr_cnt;

  logic PCWr2, PCWrCond2, PCEn2, IorD2, MemRead2, MemWr2, IRWr2, M2R2, RegDst2, regWr2, ALUSrcA2, illegal2;
  logic [1:0] ALUSrcB2, ALUop2, PCSrc2;
  logic [3:0] state2;
  logic [1:0] instr_cnt2;

  int tests = 0;
  int fails = 0;
  int model_cnt = 0;

  always #5 CLK = ~CLK;

  mcpu_ctrl #(.CNT_W(16)) u_dut (
    .CLK(CLK), .reset(reset), .Op(Op), .zero(zero), .mem_ready(mem_ready),
    .PCWr(PCWr), .PCWrCond(PCWrCond), .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead),
    .MemWr(MemWr), .IRWr(IRWr), .M2R(M2R), .RegDst(RegDst), .regWr(regWr),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop), .PCSrc(PCSrc),
    .illegal(illegal), .state(state), .instr_cnt(instr_cnt)
  );

  mcpu_ctrl #(.CNT_W(2)) u_dut2 (
    .CLK(CLK), .reset(reset), .Op(Op), .zero(zero), .mem_ready(mem_ready),
    .PCWr(PCWr2), .PCWrCond(PCWrCond2), .PCEn(PCEn2), .IorD(IorD2), .MemRead(MemRead2),
    .MemWr(MemWr2), .IRWr(IRWr2), .M2R(M2R2), .RegDst(RegDst2), .regWr(regWr2),
    .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .ALUop(ALUop2), .PCSrc(PCSrc2),
    .illegal(illegal2), .state(state2), .instr_cnt(instr_cnt2)
  );

  logic [15:0] obs_ctrl;
  assign obs_ctrl = {PCWr, PCWrCond, IorD, MemRead, MemWr, IRWr, M2R, RegDst, regWr,
                     ALUSrcA, ALUSrcB, ALUop, PCSrc};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Control word per state, same field order as obs_ctrl.
  function automatic logic [15:0] exp_ctrl(input int s, input bit rst);
    logic pcwr = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irwr = 0;
    logic m2r = 0, rdst = 0, rwr = 0, srca = 0;
    logic [1:0] srcb = 0, aop = 0, psrc = 0;
    case (s)
      0:      begin mrd = 1; irwr = 1; srcb = 2'b01; pcwr = 1; end
      1:      srcb = 2'b11;
      2, 10:  begin srca = 1; srcb = 2'b10; end
      3:      begin mrd = 1; iord = 1; end
      4:      begin m2r = 1; rwr = 1; end
      5:      begin mwr = 1; iord = 1; end
      6:      begin srca = 1; aop = 2'b10; end
      7:      begin rdst = 1; rwr = 1; end
      8:      begin srca = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
      9:      begin pcwr = 1; psrc = 2'b10; end
      11:     rwr = 1;
      default: ;
    endcase
    if (rst) begin pcwr = 0; pcwc = 0; irwr = 0; mrd = 0; mwr = 0; end
    return {pcwr, pcwc, iord, mrd, mwr, irwr, m2r, rdst, rwr, srca, srcb, aop, psrc};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'd0, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
  endfunction

  task automatic check_cycle(input int s, input bit rst, input bit exp_ill);
    logic [15:0] ec;
    ec = exp_ctrl(s, rst);
    chk("state", {28'd0, state}, s);
    chk("ctrl", {16'd0, obs_ctrl}, {16'd0, ec});
    chk("PCEn", {31'd0, PCEn}, {31'd0, ec[15] | (ec[14] & zero)});
    chk("illegal", {31'd0, illegal}, {31'd0, exp_ill});
    chk("instr_cnt", {16'd0, instr_cnt}, model_cnt & 32'hFFFF);
    chk("instr_cnt_w2", {30'd0, instr_cnt2}, model_cnt & 32'h3);
  endtask

  // Runs one instruction; steps < 0 means run it to completion.
  task automatic run_instr(input logic [5:0] op, input logic z, input int steps);
    int path[$];
    case (op)
      6'b000000: path = '{0, 1, 6, 7};
      6'b100011: path = '{0, 1, 2, 3, 4};
      6'b101011: path = '{0, 1, 2, 5};
      6'b000100: path = '{0, 1, 8};
      6'b000010: path = '{0, 1, 9};
      6'b001000: path = '{0, 1, 10, 11};
      default:   path = '{0, 1};
    endcase
    Op = op;
    zero = z;
    for (int i = 0; i < path.size(); i++) begin
      #1 check_cycle(path[i], 1'b0, (path[i] == 1) && !is_legal(op));
      if (steps >= 0 && i == steps) return;
      @(negedge CLK);
    end
    if (is_legal(op)) model_cnt++;
  endtask

  initial begin
    logic [5:0] legal_ops [6];
    logic [5:0] op;
    legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    reset = 1'b1;
    Op = 6'd0;
    zero = 1'b0;
    mem_ready = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    #1 check_cycle(0, 1'b1, 1'b0);
    reset = 1'b0;

    run_instr(6'b000000, 1'b0, -1);
    run_instr(6'b100011, 1'b0, -1);
    run_instr(6'b101011, 1'b1, -1);
    run_instr(6'b000100, 1'b1, -1);
    run_instr(6'b000100, 1'b0, -1);
    run_instr(6'b111111, 1'b0, -1);
    for (int k = 0; k < 5; k++) run_instr(6'b000010, 1'b0, -1);

    // Abandon a lw in MEMRD with an asynchronous reset.
    run_instr(6'b100011, 1'b0, 3);
    reset = 1'b1;
    model_cnt = 0;
    #1 check_cycle(0, 1'b1, 1'b0);
    @(negedge CLK);
    #1 check_cycle(0, 1'b1, 1'b0);
    reset = 1'b0;
    run_instr(6'b100011, 1'b0, -1);

`ifdef MEM_WAIT_EN
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("wait_state", {28'd0, state}, 32'd0);
      chk("wait_IRWr", {31'd0, IRWr}, 32'd0);
      chk("wait_PCWr", {31'd0, PCWr}, 32'd0);
      chk("wait_MemRead", {31'd0, MemRead}, 32'd1);
      @(negedge CLK);
    end
    mem_ready = 1'b1;
    run_instr(6'b000000, 1'b0, -1);
`endif

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 4) == 0) op = 6'($urandom);
      else op = legal_ops[$urandom_range(0, 5)];
      run_instr(op, 1'($urandom), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
